// File: rtl/udma_cfg_pkg.sv
// uDMA channel-map configuration: peripheral/channel ID constants and the
// decode helpers used by the event return path.
package udma_cfg_pkg;

    localparam int unsigned N_UART  = 2;
    localparam int unsigned N_QSPIM = 4;
    localparam int unsigned N_I2C   = 4;
    localparam int unsigned N_CPI   = 1;
    localparam int unsigned N_HYPER = 1;

    localparam int unsigned PER_ID_UART  = 0;
    localparam int unsigned PER_ID_QSPIM = 2;
    localparam int unsigned PER_ID_I2C   = 6;
    localparam int unsigned PER_ID_CPI   = 10;
    localparam int unsigned PER_ID_HYPER = 12;
    localparam int unsigned N_PERIPHS    = PER_ID_HYPER + 1 + N_HYPER;

    localparam int unsigned CH_ID_TX_UART   = 0;
    localparam int unsigned CH_ID_TX_QSPIM  = 2;
    localparam int unsigned CH_ID_CMD_QSPIM = 6;
    localparam int unsigned CH_ID_TX_I2C    = 10;
    localparam int unsigned CH_ID_CMD_I2C   = 14;
    localparam int unsigned CH_ID_TX_HYPER  = 18;
    localparam int unsigned N_TX_LIN_CHANNELS = CH_ID_TX_HYPER + N_HYPER;

    localparam int unsigned CH_ID_RX_UART  = 0;
    localparam int unsigned CH_ID_RX_QSPIM = 2;
    localparam int unsigned CH_ID_RX_I2C   = 6;
    localparam int unsigned CH_ID_RX_CPI   = 10;
    localparam int unsigned CH_ID_RX_HYPER = 11;
    localparam int unsigned N_RX_LIN_CHANNELS = CH_ID_RX_HYPER + N_HYPER;

    localparam int unsigned EVT_PER_ID_W = $clog2(N_PERIPHS);
    localparam int unsigned N_EVT_SRC    = N_TX_LIN_CHANNELS + N_RX_LIN_CHANNELS;
    localparam int unsigned EVT_CH_ID_W  = 5;

    typedef enum logic {
        EVT_DIR_TX = 1'b0,
        EVT_DIR_RX = 1'b1
    } evt_dir_e;

    typedef struct packed {
        logic [EVT_PER_ID_W-1:0] per_id;
        evt_dir_e                dir;
        logic                    cmd;
        logic [EVT_CH_ID_W-1:0]  ch_id;
    } evt_t;

    // Unsigned wraparound makes ch < base fall outside the window.
    function automatic logic in_win(input int unsigned ch, input int unsigned base,
                                    input int unsigned n);
        return (ch - base) < n;
    endfunction

    function automatic logic is_tx_cmd_ch(input int unsigned ch);
        return in_win(ch, CH_ID_CMD_QSPIM, N_QSPIM) || in_win(ch, CH_ID_CMD_I2C, N_I2C);
    endfunction

    function automatic logic [EVT_PER_ID_W-1:0] lin_tx_to_per_id(input int unsigned ch);
        int unsigned per;
        per = 0;
        if (in_win(ch, CH_ID_TX_UART, N_UART))        per = PER_ID_UART  + ch - CH_ID_TX_UART;
        else if (in_win(ch, CH_ID_TX_QSPIM, N_QSPIM)) per = PER_ID_QSPIM + ch - CH_ID_TX_QSPIM;
        else if (in_win(ch, CH_ID_CMD_QSPIM, N_QSPIM)) per = PER_ID_QSPIM + ch - CH_ID_CMD_QSPIM;
        else if (in_win(ch, CH_ID_TX_I2C, N_I2C))     per = PER_ID_I2C   + ch - CH_ID_TX_I2C;
        else if (in_win(ch, CH_ID_CMD_I2C, N_I2C))    per = PER_ID_I2C   + ch - CH_ID_CMD_I2C;
        else if (in_win(ch, CH_ID_TX_HYPER, N_HYPER)) per = PER_ID_HYPER + 1 + ch - CH_ID_TX_HYPER;
        return EVT_PER_ID_W'(per);
    endfunction

    function automatic logic [EVT_PER_ID_W-1:0] lin_rx_to_per_id(input int unsigned ch);
        int unsigned per;
        per = 0;
        if (in_win(ch, CH_ID_RX_UART, N_UART))        per = PER_ID_UART  + ch - CH_ID_RX_UART;
        else if (in_win(ch, CH_ID_RX_QSPIM, N_QSPIM)) per = PER_ID_QSPIM + ch - CH_ID_RX_QSPIM;
        else if (in_win(ch, CH_ID_RX_I2C, N_I2C))     per = PER_ID_I2C   + ch - CH_ID_RX_I2C;
        else if (in_win(ch, CH_ID_RX_CPI, N_CPI))     per = PER_ID_CPI   + ch - CH_ID_RX_CPI;
        else if (in_win(ch, CH_ID_RX_HYPER, N_HYPER)) per = PER_ID_HYPER + 1 + ch - CH_ID_RX_HYPER;
        return EVT_PER_ID_W'(per);
    endfunction

endpackage

// File: rtl/udma_evt_rr_arb.sv
// N-input round-robin arbiter: priority starts one past the last grant,
// which only advances when the grant is consumed (en_i).
module udma_evt_rr_arb #(
    parameter int unsigned N     = 31,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(last_q) + 32'd1 + k;
            if (cand >= N) cand = cand - N;
            cand_idx = IDX_W'(cand);
            if (!gnt_valid_o && req_i[cand_idx]) begin
                gnt_valid_o     = 1'b1;
                gnt_idx_o       = cand_idx;
                gnt_o[cand_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IDX_W'(N - 1);
        end else if (en_i && gnt_valid_o) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/udma_evt_router.sv
// End-of-transfer event return path: latches per-channel done pulses,
// arbitrates round-robin and presents one decoded event at a time.
module udma_evt_router
    import udma_cfg_pkg::*;
#(
    parameter int unsigned N_TX  = N_TX_LIN_CHANNELS,
    parameter int unsigned N_RX  = N_RX_LIN_CHANNELS,
    parameter int unsigned PER_W = $clog2(N_PERIPHS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_TX-1:0]  tx_done_i,
    input  logic [N_RX-1:0]  rx_done_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [PER_W-1:0] evt_per_id_o,
    output logic             evt_dir_o,
    output logic             evt_cmd_o,
    output logic [4:0]       evt_ch_id_o,
    output logic             overflow_o,
    output logic [4:0]       overflow_src_o
);

    localparam int unsigned N_SRC = N_TX + N_RX;
    localparam int unsigned SRC_W = $clog2(N_SRC);

    logic [N_SRC-1:0] src_pulse;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] gnt;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] hit;
    logic [SRC_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             load;
    int unsigned      src_ch;

    logic             evt_valid_q;
    evt_t             evt_q;
    evt_t             evt_d;
    logic             ovf_d;
    logic [4:0]       ovf_src_d;
    logic             ovf_q;
    logic [4:0]       ovf_src_q;

    assign src_pulse = {rx_done_i, tx_done_i};
    assign load      = gnt_valid & (~evt_valid_q | evt_ready_i);

    udma_evt_rr_arb #(
        .N     (N_SRC),
        .IDX_W (SRC_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (pending_q),
        .en_i        (load),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // A pulse landing on the bit being loaded this cycle re-arms it rather
    // than counting as lost.
    always_comb begin
        clr       = load ? gnt : '0;
        hit       = src_pulse & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | src_pulse;
        ovf_d     = 1'b0;
        ovf_src_d = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (hit[k] && !ovf_d) begin
                ovf_d     = 1'b1;
                ovf_src_d = 5'(k);
            end
        end
    end

    always_comb begin
        evt_d  = '0;
        src_ch = 32'(gnt_idx);
        if (src_ch >= N_TX) begin
            src_ch       = src_ch - N_TX;
            evt_d.dir    = EVT_DIR_RX;
            evt_d.ch_id  = 5'(src_ch);
            evt_d.per_id = lin_rx_to_per_id(src_ch);
        end else begin
            evt_d.dir    = EVT_DIR_TX;
            evt_d.ch_id  = 5'(src_ch);
            evt_d.per_id = lin_tx_to_per_id(src_ch);
            evt_d.cmd    = is_tx_cmd_ch(src_ch);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_q       <= '0;
            ovf_q       <= 1'b0;
            ovf_src_q   <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ovf_src_q <= ovf_src_d;
            if (load) begin
                evt_valid_q <= 1'b1;
                evt_q       <= evt_d;
            end else if (evt_ready_i) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

    assign evt_valid_o    = evt_valid_q;
    assign evt_per_id_o   = PER_W'(evt_q.per_id);
    assign evt_dir_o      = evt_q.dir;
    assign evt_cmd_o      = evt_q.cmd;
    assign evt_ch_id_o    = evt_q.ch_id;
    assign overflow_o     = ovf_q;
    assign overflow_src_o = ovf_src_q;

endmodule

// File: tb/tb_udma_evt_router.sv
// Directed self-checking bench for udma_evt_router.
module tb_udma_evt_router;

    logic        clk;
    logic        rst;
    logic [18:0] tx_done;
    logic [11:0] rx_done;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_per_id;
    logic        evt_dir;
    logic        evt_cmd;
    logic [4:0]  evt_ch_id;
    logic        overflow;
    logic [4:0]  overflow_src;

    int errors = 0;
    int checks = 0;

    // {valid, per_id, dir, cmd, ch_id}
    logic [11:0] obs;
    assign obs = {evt_valid, evt_per_id, evt_dir, evt_cmd, evt_ch_id};

    udma_evt_router dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tx_done_i      (tx_done),
        .rx_done_i      (rx_done),
        .evt_valid_o    (evt_valid),
        .evt_ready_i    (evt_ready),
        .evt_per_id_o   (evt_per_id),
        .evt_dir_o      (evt_dir),
        .evt_cmd_o      (evt_cmd),
        .evt_ch_id_o    (evt_ch_id),
        .overflow_o     (overflow),
        .overflow_src_o (overflow_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_done = '0;
        rx_done = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        evt_ready = 1'b0;
        do_reset();
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL reset_evt: got %h want %h", obs, 12'h000);
        end
        checks++;
        if ({overflow, overflow_src} !== 6'h00) begin
            errors++;
            $display("FAIL reset_ovf: got %h want %h", {overflow, overflow_src}, 6'h00);
        end
    endtask

    task automatic test_decode();
        // {is_rx, ch, per, cmd}
        logic [11:0] vec [7];
        logic [11:0] exp;
        vec[0] = {1'b0, 5'd7,  4'd3,  1'b1, 1'b0};
        vec[1] = {1'b1, 5'd11, 4'd13, 1'b0, 1'b0};
        vec[2] = {1'b1, 5'd10, 4'd10, 1'b0, 1'b0};
        vec[3] = {1'b0, 5'd18, 4'd13, 1'b0, 1'b0};
        vec[4] = {1'b0, 5'd15, 4'd7,  1'b1, 1'b0};
        vec[5] = {1'b0, 5'd12, 4'd8,  1'b0, 1'b0};
        vec[6] = {1'b1, 5'd4,  4'd4,  1'b0, 1'b0};
        evt_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (vec[i][11]) rx_done[vec[i][10:6]] = 1'b1;
            else            tx_done[vec[i][10:6]] = 1'b1;
            step();
            tx_done = '0;
            rx_done = '0;
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL decode%0d_early: valid got %b want 0", i, evt_valid);
            end
            step();
            exp = {1'b1, vec[i][5:2], vec[i][11], vec[i][1], vec[i][10:6]};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL decode%0d_evt: got %h want %h", i, obs, exp);
            end
            step();
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL decode%0d_once: valid got %b want 0", i, evt_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp [4];
        exp[0] = {1'b1, 4'd0, 1'b0, 1'b0, 5'd0};
        exp[1] = {1'b1, 4'd5, 1'b0, 1'b0, 5'd5};
        exp[2] = {1'b1, 4'd3, 1'b1, 1'b0, 5'd3};
        exp[3] = 12'h000 | (obs & 12'h7ff) & 12'h000;
        evt_ready = 1'b1;
        do_reset();
        tx_done[0] = 1'b1;
        tx_done[5] = 1'b1;
        rx_done[3] = 1'b1;
        step();
        tx_done = '0;
        rx_done = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL b2b_evt%0d: got %h want %h", i, obs, exp[i]);
            end
        end
        step();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid got %b want 0", evt_valid);
        end
    endtask

    task automatic test_overflow();
        logic [11:0] exp [3];
        exp[0] = {1'b1, 4'd2, 1'b0, 1'b0, 5'd2};
        exp[1] = {1'b1, 4'd5, 1'b0, 1'b1, 5'd9};
        exp[2] = {1'b1, 4'd1, 1'b1, 1'b0, 5'd1};
        evt_ready = 1'b0;
        do_reset();
        // occupy the output slot with tx0 so later pulses stay pending
        tx_done[0] = 1'b1;
        step();
        tx_done = '0;
        step();
        tx_done[2] = 1'b1;
        step();
        tx_done = '0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_first: got %b want 0", overflow);
        end
        step();
        step();
        step();
        checks++;
        if (obs !== {1'b1, 4'd0, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL ovf_stall: got %h want %h", obs, {1'b1, 4'd0, 1'b0, 1'b0, 5'd0});
        end
        tx_done[2] = 1'b1;
        step();
        tx_done = '0;
        checks++;
        if ({overflow, overflow_src} !== {1'b1, 5'd2}) begin
            errors++;
            $display("FAIL ovf_tx2: got %h want %h", {overflow, overflow_src}, {1'b1, 5'd2});
        end
        step();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_pulse: got %b want 0", overflow);
        end
        tx_done[9] = 1'b1;
        rx_done[1] = 1'b1;
        step();
        step();
        checks++;
        if ({overflow, overflow_src} !== {1'b1, 5'd9}) begin
            errors++;
            $display("FAIL ovf_lowest: got %h want %h", {overflow, overflow_src}, {1'b1, 5'd9});
        end
        tx_done = '0;
        rx_done = '0;
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL ovf_drain%0d: got %h want %h", i, obs, exp[i]);
            end
        end
        step();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_merged: valid got %b want 0", evt_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [11:0] exp;
        evt_ready = 1'b1;
        do_reset();
        tx_done[0] = 1'b1;
        tx_done[1] = 1'b1;
        step();
        checks++;
        if ({evt_valid, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL rr_start: got %b want 00", {evt_valid, overflow});
        end
        // re-pulse each channel in the cycle it is being loaded
        for (int i = 0; i < 6; i++) begin
            tx_done = '0;
            tx_done[i % 2] = 1'b1;
            step();
            exp = {1'b1, 4'(i % 2), 1'b0, 1'b0, 5'(i % 2)};
            checks++;
            if ({obs, overflow} !== {exp, 1'b0}) begin
                errors++;
                $display("FAIL rr_grant%0d: got %h/%b want %h/0", i, obs, overflow, exp);
            end
        end
        tx_done = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            exp = {1'b1, 4'(i), 1'b0, 1'b0, 5'(i)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rr_tail%0d: got %h want %h", i, obs, exp);
            end
        end
        step();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: valid got %b want 0", evt_valid);
        end
    endtask

    task automatic test_mid_reset();
        evt_ready = 1'b0;
        do_reset();
        tx_done[3] = 1'b1;
        rx_done[0] = 1'b1;
        step();
        tx_done = '0;
        rx_done = '0;
        step();
        checks++;
        if (obs !== {1'b1, 4'd3, 1'b0, 1'b0, 5'd3}) begin
            errors++;
            $display("FAIL mrst_pre: got %h want %h", obs, {1'b1, 4'd3, 1'b0, 1'b0, 5'd3});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({evt_valid, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL mrst_edge: got %b want 00", {evt_valid, overflow});
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL mrst_quiet%0d: valid got %b want 0", i, evt_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_done = '0;
        rx_done = '0;
        evt_ready = 1'b0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_overflow();
        test_round_robin();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
